// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and defaults for the count_seq_ctrl block.
//   state_e      - sequencer states (idle, counting, paused, terminal)
//   DefaultWidth - default counter width in bits
//   DefaultWrapW - default wrap-event counter width in bits
package count_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultWrapW = 8;

endpackage

// File: rtl/count_seq_step.sv
// count_seq_step: combinational up/down step for the sequencer counter.
//   counter_i - current count
//   up_dn_i   - 1 = increment, 0 = decrement
//   next_o    - count one step on, modulo 2^Width
//   wrap_o    - the step crosses the all-ones/zero boundary
module count_seq_step #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] counter_i,
  input  logic             up_dn_i,
  output logic [Width-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] One = Width'(1);

  always_comb begin
    if (up_dn_i) begin
      next_o = counter_i + One;
      wrap_o = &counter_i;
    end else begin
      next_o = counter_i - One;
      wrap_o = ~|counter_i;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: start/stop/pause controlled up/down counter sequencer that
// counts from its current value until it reaches a terminal limit.
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   start/stop/pause    - sequencing controls (start only honoured in idle)
//   up_dn               - count direction, 1 = up
//   load, load_val      - synchronous load of the counter, any state
//   limit               - terminal value that ends a run
//   counter             - registered count
//   running             - high while counting or paused
//   done                - one-cycle pulse on reaching the limit
//   wrap                - one-cycle pulse in the cycle the count has wrapped
//   wrap_cnt            - saturating wraps-since-start count; only present
//                         when COUNT_SEQ_WRAP_CNT_EN is defined
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned WRAP_W = DefaultWrapW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  counter,
  output logic              running,
  output logic              done,
  output logic              wrap
`ifdef COUNT_SEQ_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  if (WIDTH < 2 || WIDTH > 16 || WRAP_W < 1) begin : g_param_check
    $error("count_seq_ctrl: WIDTH must be 2..16 and WRAP_W at least 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             run_entry;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;

  count_seq_step #(
    .Width (WIDTH)
  ) u_step (
    .counter_i (counter_q),
    .up_dn_i   (up_dn),
    .next_o    (step_next),
    .wrap_o    (step_wrap)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    run_entry = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop outranks load and start even with nothing to abort
        if (!stop) begin
          if (load) begin
            counter_d = load_val;
          end
          if (start) begin
            state_d   = StRun;
            run_entry = 1'b1;
          end
        end
      end

      StRun, StPause: begin
        if (stop) begin
          state_d = StIdle;
        end else if (load) begin
          counter_d = load_val;
          if (load_val == limit) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = pause ? StPause : StRun;
          end
        end else if (pause) begin
          state_d = StPause;
        end else if (state_q == StPause) begin
          // leaving pause costs one edge; the step happens on the next one
          state_d = StRun;
        end else begin
          counter_d = step_next;
          wrap_d    = step_wrap;
          if (step_next == limit) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        if (!stop && load) begin
          counter_d = load_val;
        end
      end

      default: state_d = StIdle;
    endcase

    running_d = (state_d == StRun) || (state_d == StPause);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      counter_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      running_q <= running_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter = counter_q;
  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

`ifdef COUNT_SEQ_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (run_entry) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && !(&wrap_cnt_q)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  logic unused_run_entry;
  assign unused_run_entry = run_entry;
`endif

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 Parameter WRAP_W, default 8, wrap-event counter width.
REQ-003 clock  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin counting; honoured only in IDLE.
REQ-006 stop  input  1  request to abort counting; returns to IDLE.
REQ-007 pause  input  1  level; holds count while high in RUN.
REQ-008 up_dn  input  1  direction, 1 = increment, 0 = decrement; sampled each counting cycle.
REQ-009 load  input  1  synchronous load of load_val into counter, any state.
REQ-010 load_val  input  WIDTH  load value.
REQ-011 limit  input  WIDTH  terminal value; RUN ends when counter equals limit.
REQ-012 counter  output  WIDTH  registered count, feeds the downstream register stage.
REQ-013 running  output  1  high in RUN and PAUSE.
REQ-014 done  output  1  one-cycle pulse on RUN/PAUSE -> DONE transition.
REQ-015 wrap  output  1  one-cycle pulse when counter wraps (all-ones->0 up, 0->all-ones down).
REQ-016 wrap_cnt  output  WRAP_W  number of wraps since start (present only with macro, REQ-033).

Function
REQ-017 FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-018 IDLE: counter holds; start=1 -> RUN next cycle, counter unchanged on that edge.
REQ-019 RUN: counter +1 or -1 per clock per up_dn; pause=1 -> PAUSE without counting that cycle.
REQ-020 PAUSE: counter holds; pause=0 -> RUN; counting resumes next edge.
REQ-021 RUN/PAUSE: when the next counter value equals limit, counter takes limit and FSM -> DONE; done pulses the same cycle FSM enters DONE.
REQ-022 DONE: counter holds; one cycle later FSM -> IDLE automatically.
REQ-023 Arithmetic modulo 2^WIDTH; wrap pulses in the cycle counter shows the wrapped value.
REQ-024 Priority per edge: stop > load > count step.
REQ-025 stop in RUN/PAUSE/DONE -> IDLE next cycle, counter holds, no done pulse.
REQ-026 load in RUN: counter <= load_val, no step that cycle, no wrap pulse; if load_val equals limit, FSM -> DONE with done pulse.
REQ-027 start while not IDLE is ignored; start and stop together in IDLE: stays IDLE.
REQ-028 start in IDLE with counter already equal to limit: RUN entered, counts full modulus before DONE.

Reset
REQ-029 reset=0 forces asynchronously: state IDLE, counter 0, running 0, done 0, wrap 0, wrap_cnt 0.
REQ-030 Reset mid-RUN aborts with no done pulse; deassertion is clean with respect to clock (synchronised release outside this block).
REQ-031 Every flop in the block has the reset; no flop powers up undefined.

Configuration
REQ-032 Macro COUNT_SEQ_WRAP_CNT_EN gates the wrap-event counter.
REQ-033 Defined: wrap_cnt port exists, clears on entry to RUN from IDLE, increments on each wrap pulse, saturates at all-ones.
REQ-034 Undefined: wrap_cnt port and its logic absent; all other behaviour identical.

Structure
REQ-035 Package count_seq_pkg holds the state enum typedef (IDLE, RUN, PAUSE, DONE) and default WIDTH/WRAP_W constants.
REQ-036 One sub-module count_seq_step: combinational next-count and wrap-detect from counter, up_dn; FSM and registers stay in top.

Verification
REQ-037 WIDTH=4, limit=5, up: reset, start -> counter 0,1,..,5 on successive RUN cycles, done pulse once at 5, IDLE one cycle later.
REQ-038 Counter=14, limit=2, up: 15,0(wrap=1),1,2 done; wrap_cnt=1 with macro.
REQ-039 Down from 1, limit=14: 0,15(wrap=1),14 done.
REQ-040 Pause high 3 cycles mid-run at counter=3 -> counter stays 3 for 3 cycles, running=1, then resumes 4.
REQ-041 Stop and load same cycle in RUN at counter=6 -> IDLE, counter 6, no done.
REQ-042 reset pulsed low mid-RUN between clock edges -> outputs zero immediately, start afterwards counts from 0.
